// File: rtl/ca_cmd_scheduler_if.sv
// Command-scheduler bus: requester side (per-requester command fields plus
// one-hot grant) and distributor side (CA beat, valid, rank tag, ready).
//   master : drives requests and distributor ready, observes grants/beats
//   slave  : the scheduler itself
interface ca_cmd_scheduler_if #(
  parameter int NUM_REQ   = 3,
  parameter int CA_WIDTH  = 14,
  parameter int RANK_BITS = 2
);
  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0][2*CA_WIDTH-1:0]     req_ca;
  logic [NUM_REQ-1:0][RANK_BITS-1:0]      req_rank;
  logic [NUM_REQ-1:0]                     req_two_beat;
  logic [NUM_REQ-1:0]                     req_urgent;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [CA_WIDTH-1:0]                    ca_out;
  logic                                   ca_valid_out;
  logic [RANK_BITS-1:0]                   ca_rank_out;
  logic                                   ca_ready_in;

  modport master (
    output req_valid, req_ca, req_rank, req_two_beat, req_urgent, ca_ready_in,
    input  req_ready, ca_out, ca_valid_out, ca_rank_out
  );

  modport slave (
    input  req_valid, req_ca, req_rank, req_two_beat, req_urgent, ca_ready_in,
    output req_ready, ca_out, ca_valid_out, ca_rank_out
  );
endinterface

// File: rtl/ca_cmd_scheduler.sv
// CA command scheduler: arbitrates NUM_REQ command sources onto the single CA
// input of the distributor. One atomic 1- or 2-beat command is issued at a
// time; a programmable idle gap follows each command. Urgent requests win
// (lowest index first), otherwise round-robin from rr_ptr.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       permits new grants
//   cfg_gap      idle cycles after each command's final beat
//   bus          slave side of ca_cmd_scheduler_if (requests/grants, CA beats)
//   grant_id     index of the last granted requester
//   busy         high whenever the FSM is not idle
//   cmd_count    commands completed, wrapping
module ca_cmd_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int CA_WIDTH  = 14,
  parameter int RANK_BITS = 2,
  parameter int GAP_BITS  = 4,
  localparam int GRANT_W  = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [GAP_BITS-1:0] cfg_gap,
  ca_cmd_scheduler_if.slave   bus,
  output logic [GRANT_W-1:0]  grant_id,
  output logic                busy,
  output logic [31:0]         cmd_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND0 = 2'd1;
  localparam logic [1:0] SEND1 = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]          state;
  logic [GRANT_W-1:0]  rr_ptr;
  logic [GAP_BITS-1:0] gap_cnt;
  logic                two_beat;
  logic [CA_WIDTH-1:0] beat1;

  logic                final_beat;
  logic                arb_point;
  logic                grant;
  logic [GRANT_W-1:0]  winner;
  logic                found;
  logic [GRANT_W:0]    rr_sum;
  logic [GRANT_W-1:0]  rr_idx;

  // The beat on the bus this cycle is the last one of the current command.
  assign final_beat = bus.ca_ready_in &&
                      (((state == SEND0) && !two_beat) || (state == SEND1));
  // Back-to-back issue is only possible when no gap is requested.
  assign arb_point  = (state == IDLE) || (final_beat && (cfg_gap == '0));
  assign grant      = rst_n && enable && (|bus.req_valid) && arb_point;
  assign busy       = (state != IDLE);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && bus.req_urgent[i]) begin
        winner = GRANT_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, rr_ptr} + (GRANT_W+1)'(i);
      if (rr_sum >= (GRANT_W+1)'(NUM_REQ))
        rr_sum = rr_sum - (GRANT_W+1)'(NUM_REQ);
      rr_idx = rr_sum[GRANT_W-1:0];
      if (!found && bus.req_valid[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant)
      bus.req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      gap_cnt          <= '0;
      two_beat         <= 1'b0;
      beat1            <= '0;
      bus.ca_out       <= '0;
      bus.ca_valid_out <= 1'b0;
      bus.ca_rank_out  <= '0;
      grant_id         <= '0;
      cmd_count        <= '0;
    end else begin
      if (final_beat)
        cmd_count <= cmd_count + 32'd1;

      if (grant) begin
        // Whole command is captured now; req_valid may drop afterwards.
        bus.ca_out       <= bus.req_ca[winner][CA_WIDTH-1:0];
        beat1            <= bus.req_ca[winner][2*CA_WIDTH-1:CA_WIDTH];
        bus.ca_rank_out  <= bus.req_rank[winner];
        two_beat         <= bus.req_two_beat[winner];
        grant_id         <= winner;
        bus.ca_valid_out <= 1'b1;
        state            <= SEND0;
        // Urgent grants also advance the pointer.
        if (winner == GRANT_W'(NUM_REQ-1))
          rr_ptr <= '0;
        else
          rr_ptr <= winner + 1'b1;
      end else if (final_beat) begin
        bus.ca_valid_out <= 1'b0;
        if (cfg_gap != '0) begin
          gap_cnt <= cfg_gap;
          state   <= GAP;
        end else begin
          state   <= IDLE;
        end
      end else if ((state == SEND0) && bus.ca_ready_in) begin
        // Not final, so this is a two-beat command: move to beat1.
        bus.ca_out <= beat1;
        state      <= SEND1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
        if (gap_cnt == GAP_BITS'(1))
          state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ca_cmd_scheduler.sv
module tb_ca_cmd_scheduler;

  localparam int N  = 3;
  localparam int CW = 14;
  localparam int RB = 2;
  localparam int GB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [GB-1:0] cfg_gap;
  logic [1:0]    grant_id;
  logic          busy;
  logic [31:0]   cmd_count;

  int n_checks = 0;
  int n_pass   = 0;

  ca_cmd_scheduler_if #(.NUM_REQ(N), .CA_WIDTH(CW), .RANK_BITS(RB)) bus ();

  ca_cmd_scheduler #(.NUM_REQ(N), .CA_WIDTH(CW), .RANK_BITS(RB), .GAP_BITS(GB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_gap   (cfg_gap),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: urgent lowest index, else first valid upward from rr with wrap.
  function automatic int exp_winner(input logic [N-1:0] v, input logic [N-1:0] u, input int rr);
    for (int i = 0; i < N; i++)
      if (v[i] && u[i]) return i;
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  // Transaction-level model: queue of beats still owed to the distributor,
  // remaining idle gap, round-robin pointer, last grant, completed count.
  typedef struct packed {
    logic [CW-1:0] ca;
    logic [RB-1:0] rank;
  } beat_t;

  beat_t       pend[$];
  beat_t       nb;
  int          gap_left = 0;
  int          m_rr     = 0;
  int          m_gid    = 0;
  logic [31:0] m_cnt    = '0;
  bit          m_acc, m_fin, m_ap, m_eg;
  int          m_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      gap_left = 0;
      m_rr     = 0;
      m_gid    = 0;
      m_cnt    = '0;
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_ca_valid", 64'(bus.ca_valid_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cmd_count", 64'(cmd_count), 64'd0);
    end else begin
      m_acc = (pend.size() != 0) && bus.ca_ready_in;
      m_fin = m_acc && (pend.size() == 1);
      m_ap  = ((pend.size() == 0) && (gap_left == 0)) || (m_fin && (cfg_gap == '0));
      m_eg  = m_ap && enable && (|bus.req_valid);
      m_w   = exp_winner(bus.req_valid, bus.req_urgent, m_rr);
      check("req_ready", 64'(bus.req_ready), m_eg ? 64'(1 << m_w) : 64'd0);
      check("ca_valid", 64'(bus.ca_valid_out), 64'(pend.size() != 0));
      if (pend.size() != 0) begin
        check("ca_out", 64'(bus.ca_out), 64'(pend[0].ca));
        check("ca_rank", 64'(bus.ca_rank_out), 64'(pend[0].rank));
      end
      check("busy", 64'(busy), 64'((pend.size() != 0) || (gap_left != 0)));
      check("cmd_count", 64'(cmd_count), 64'(m_cnt));
      check("grant_id", 64'(grant_id), 64'(m_gid));
      if ((pend.size() == 0) && (gap_left > 0)) gap_left--;
      if (m_acc) void'(pend.pop_front());
      if (m_fin) begin
        m_cnt = m_cnt + 32'd1;
        if (cfg_gap != '0) gap_left = int'(cfg_gap);
      end
      if (m_eg) begin
        nb.ca   = bus.req_ca[m_w][CW-1:0];
        nb.rank = bus.req_rank[m_w];
        pend.push_back(nb);
        if (bus.req_two_beat[m_w]) begin
          nb.ca = bus.req_ca[m_w][2*CW-1:CW];
          pend.push_back(nb);
        end
        m_rr  = (m_w + 1) % N;
        m_gid = m_w;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid    = '0;
    bus.req_ca       = '0;
    bus.req_rank     = '0;
    bus.req_two_beat = '0;
    bus.req_urgent   = '0;
  endtask

  task automatic set_req(input int i, input bit two, input bit urg,
                         input logic [2*CW-1:0] ca, input logic [RB-1:0] rank);
    bus.req_valid[i]    = 1'b1;
    bus.req_two_beat[i] = two;
    bus.req_urgent[i]   = urg;
    bus.req_ca[i]       = ca;
    bus.req_rank[i]     = rank;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    clear_reqs();
    enable          = 1'b1;
    cfg_gap         = '0;
    bus.ca_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b1;
    cfg_gap         = '0;
    bus.ca_ready_in = 1'b1;
    clear_reqs();
    bus.req_valid   = 3'b111;

    // Reset: no grant pulse even with requests pending.
    sample();
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_valid", 64'(bus.ca_valid_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_count", 64'(cmd_count), 64'd0);
    do_reset();

    // Single-beat command from req1.
    set_req(1, 1'b0, 1'b0, 28'h0000123, 2'd2);
    sample();
    check("t1_grant", 64'(bus.req_ready), 64'b010);
    tick();
    clear_reqs();
    sample();
    check("t1_valid", 64'(bus.ca_valid_out), 64'd1);
    check("t1_ca", 64'(bus.ca_out), 64'h0123);
    check("t1_rank", 64'(bus.ca_rank_out), 64'd2);
    tick();
    sample();
    check("t1_valid_off", 64'(bus.ca_valid_out), 64'd0);
    check("t1_count", 64'(cmd_count), 64'd1);

    // Two-beat command stalled in SEND0, req2 waiting.
    do_reset();
    set_req(0, 1'b1, 1'b0, {14'h2222, 14'h1111}, 2'd1);
    set_req(2, 1'b0, 1'b0, 28'h0000abc, 2'd3);
    bus.ca_ready_in = 1'b0;
    sample();
    check("t2_grant0", 64'(bus.req_ready), 64'b001);
    tick();
    bus.req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t2_hold_beat0", 64'(bus.ca_out), 64'h1111);
      check("t2_no_grant", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.ca_ready_in = 1'b1;
    sample();
    check("t2_beat0_last", 64'(bus.ca_out), 64'h1111);
    check("t2_atomic", 64'(bus.req_ready), 64'd0);
    tick();
    sample();
    check("t2_beat1", 64'(bus.ca_out), 64'h2222);
    check("t2_grant2", 64'(bus.req_ready), 64'b100);
    tick();
    clear_reqs();
    sample();
    check("t2_next_cmd", 64'(bus.ca_out), 64'h0abc);

    // Round-robin back-to-back at full throughput.
    do_reset();
    set_req(0, 1'b0, 1'b0, 28'h0000010, 2'd0);
    set_req(1, 1'b0, 1'b0, 28'h0000011, 2'd1);
    set_req(2, 1'b0, 1'b0, 28'h0000012, 2'd2);
    for (int g = 0; g < 5; g++) begin
      sample();
      check("t3_rr_grant", 64'(bus.req_ready), 64'(1 << (g % 3)));
      if (g > 0) check("t3_continuous", 64'(bus.ca_valid_out), 64'd1);
      tick();
    end
    clear_reqs();

    // Urgent priority, pointer still advances past the urgent winner.
    do_reset();
    set_req(0, 1'b0, 1'b0, 28'h0000020, 2'd0);
    set_req(1, 1'b0, 1'b0, 28'h0000021, 2'd1);
    set_req(2, 1'b0, 1'b1, 28'h0000022, 2'd2);
    sample();
    check("t4_urgent", 64'(bus.req_ready), 64'b100);
    tick();
    bus.req_urgent = '0;
    sample();
    check("t4_after_urgent", 64'(bus.req_ready), 64'b001);
    tick();
    clear_reqs();

    // Idle gap of 3 cycles between two queued commands.
    do_reset();
    cfg_gap = 4'd3;
    set_req(0, 1'b0, 1'b0, 28'h0000030, 2'd0);
    set_req(1, 1'b0, 1'b0, 28'h0000031, 2'd1);
    sample();
    check("t5_grant0", 64'(bus.req_ready), 64'b001);
    tick();
    bus.req_valid[0] = 1'b0;
    sample();
    check("t5_beat", 64'(bus.ca_valid_out), 64'd1);
    check("t5_no_b2b", 64'(bus.req_ready), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t5_gap_valid", 64'(bus.ca_valid_out), 64'd0);
      check("t5_gap_busy", 64'(busy), 64'd1);
      check("t5_gap_no_grant", 64'(bus.req_ready), 64'd0);
      tick();
    end
    sample();
    check("t5_idle_busy", 64'(busy), 64'd0);
    check("t5_grant1", 64'(bus.req_ready), 64'b010);
    tick();
    clear_reqs();
    cfg_gap = '0;
    sample();
    check("t5_second", 64'(bus.ca_out), 64'h0031);

    // Reset during SEND1 aborts the command.
    do_reset();
    set_req(0, 1'b1, 1'b0, {14'h0bbb, 14'h0aaa}, 2'd1);
    sample();
    tick();
    clear_reqs();
    sample();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_abort_valid", 64'(bus.ca_valid_out), 64'd0);
    check("t6_abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_count", 64'(cmd_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t6_no_replay", 64'(bus.ca_valid_out), 64'd0);
      tick();
    end

    // Randomized traffic checked by the reference model.
    for (int c = 0; c < 2000; c++) begin
      bus.req_valid    = N'($urandom);
      bus.req_urgent   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      bus.req_two_beat = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_ca[i]   = (2*CW)'($urandom);
        bus.req_rank[i] = RB'($urandom);
      end
      bus.ca_ready_in = ($urandom_range(0, 3) != 0);
      enable          = ($urandom_range(0, 15) != 0);
      cfg_gap         = ($urandom_range(0, 4) < 3) ? '0 : GB'($urandom_range(1, 3));
      tick();
    end
    clear_reqs();
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
